// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM stage: FSM state encoding, alignment mask
// and the request snapshot latched when a memory access issues.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_t;

  // The access address doubles as the latched ALU result: an access only
  // issues when it is word aligned, so the two are identical.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_to_reg;
  } mem_req_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port. Handshake: a request transfers on every cycle where
// req && gnt; a read answers later with one rvalid cycle carrying rdata.
interface mem_stage_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             gnt;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: drives the data-memory handshake,
// stalls upstream while an access is outstanding, and acts as the MEM/WB register.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_out_in,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             mem_to_reg_in,
  mem_stage_if.master      dmem,
  output logic             stall_o,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic             misalign_o,
  output logic [WIDTH-1:0] misalign_addr,
  output mem_state_t       state_dbg
);

  mem_state_t state_q, state_d;
  mem_req_t   req_q;

  logic acc, misal, issue, idle_misal;
  logic complete, use_latched;

  logic [WIDTH-1:0] sel_alu;
  logic [4:0]       sel_rd;
  logic             sel_reg_write, sel_mem_to_reg;

  assign acc        = mem_read_in | mem_write_in;
  assign misal      = acc && (alu_out_in[1:0] != 2'b00);
  assign issue      = (state_q == IDLE) && acc && !misal;
  assign idle_misal = (state_q == IDLE) && misal;
  assign state_dbg  = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a simultaneous read+write is a store
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          if (!dmem.gnt)        state_d = WAIT_GNT;
          else if (!mem_write_in) state_d = WAIT_RSP;
        end
      end
      WAIT_GNT: begin
        if (dmem.gnt) state_d = req_q.we ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (dmem.rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: bus drive, stall and writeback-completion qualifiers
  always_comb begin
    dmem.req    = 1'b0;
    dmem.we     = 1'b0;
    dmem.addr   = '0;
    dmem.wdata  = '0;
    stall_o     = 1'b0;
    complete    = 1'b0;
    use_latched = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          dmem.req   = 1'b1;
          dmem.we    = mem_write_in;
          dmem.addr  = alu_out_in & WORD_ALIGN_MASK;
          dmem.wdata = store_data_in;
          stall_o    = !(dmem.gnt && mem_write_in);
        end
        complete = !stall_o && !misal;
      end
      WAIT_GNT: begin
        dmem.req    = 1'b1;
        dmem.we     = req_q.we;
        dmem.addr   = req_q.addr;
        dmem.wdata  = req_q.wdata;
        stall_o     = !(dmem.gnt && req_q.we);
        complete    = !stall_o;
        use_latched = 1'b1;
      end
      WAIT_RSP: begin
        stall_o     = !dmem.rvalid;
        complete    = dmem.rvalid;
        use_latched = 1'b1;
      end
      default: ;
    endcase
  end

  assign sel_alu        = use_latched ? req_q.addr       : alu_out_in;
  assign sel_rd         = use_latched ? req_q.rd         : rd_in;
  assign sel_reg_write  = use_latched ? req_q.reg_write  : reg_write_in;
  assign sel_mem_to_reg = use_latched ? req_q.mem_to_reg : mem_to_reg_in;

  // Request snapshot, writeback register and misalignment report
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      misalign_o    <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_o <= idle_misal;
      if (idle_misal) misalign_addr <= alu_out_in;
      if (issue) begin
        req_q.addr       <= alu_out_in & WORD_ALIGN_MASK;
        req_q.wdata      <= store_data_in;
        req_q.we         <= mem_write_in;
        req_q.rd         <= rd_in;
        req_q.reg_write  <= reg_write_in;
        req_q.mem_to_reg <= mem_to_reg_in;
      end
      if (complete) begin
        wb_data      <= sel_mem_to_reg ? dmem.rdata : sel_alu;
        wb_rd        <= sel_rd;
        wb_reg_write <= sel_reg_write && (sel_rd != 5'd0);
      end else begin
        wb_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random instruction mix against
// a transaction-level model of the MEM stage and a word-addressed memory.
module tb_mem_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_in, store_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        stall_o, wb_reg_write, misalign_o;
  logic [31:0] wb_data, misalign_addr;
  logic [4:0]  wb_rd;
  mem_state_t  state_dbg;

  mem_stage_if #(.WIDTH(32)) dmem_bus ();

  mem_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alu_out_in(alu_out_in), .store_data_in(store_data_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .dmem(dmem_bus),
    .stall_o(stall_o), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .misalign_o(misalign_o),
    .misalign_addr(misalign_addr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic idle_inputs();
    alu_out_in = '0; store_data_in = '0; rd_in = '0;
    reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
    dmem_bus.gnt = 0; dmem_bus.rvalid = 0; dmem_bus.rdata = '0;
  endtask

  // Presents one instruction, plays the memory (grant after gw waits, response
  // rwt cycles after grant) and returns what it saw until the stage completes.
  task automatic drive_op(
    input  logic ld, input logic st, input logic [31:0] addr, input logic [31:0] sd,
    input  logic [4:0] rd, input logic rw, input logic m2r, input int gw, input int rwt,
    output int req_n, output int stall_n, output int bubble_bad,
    output logic [31:0] b_addr, output logic [31:0] b_wdata, output logic b_we,
    output logic timeout
  );
    int cyc, gcnt, rcnt;
    bit granted, done;
    cyc = 0; gcnt = 0; rcnt = 0; granted = 0; done = 0;
    req_n = 0; stall_n = 0; bubble_bad = 0;
    b_addr = '0; b_wdata = '0; b_we = 0;
    @(negedge clk);
    alu_out_in = addr; store_data_in = sd; rd_in = rd; reg_write_in = rw;
    mem_read_in = ld; mem_write_in = st; mem_to_reg_in = m2r;
    while (!done && cyc < 60) begin
      if (cyc > 0) begin
        alu_out_in = $urandom; store_data_in = $urandom; rd_in = 5'($urandom);
        reg_write_in = 1'($urandom); mem_read_in = 1'($urandom);
        mem_write_in = 1'($urandom); mem_to_reg_in = 1'($urandom);
      end
      dmem_bus.gnt = 0; dmem_bus.rvalid = 0; dmem_bus.rdata = $urandom;
      if (!granted) dmem_bus.rvalid = 1'($urandom_range(0, 1));
      #1;
      if (dmem_bus.req) begin
        req_n++;
        if (req_n == 1) begin
          b_addr = dmem_bus.addr; b_wdata = dmem_bus.wdata; b_we = dmem_bus.we;
        end
        if (gcnt == gw) begin
          dmem_bus.gnt = 1; granted = 1;
          if (dmem_bus.we) mem_model[dmem_bus.addr] = dmem_bus.wdata;
        end else begin
          gcnt++;
        end
      end else if (granted && !b_we) begin
        rcnt++;
        if (rcnt == rwt) begin
          dmem_bus.rvalid = 1; dmem_bus.rdata = mem_rd(b_addr);
        end
      end
      #1;
      if (stall_o) stall_n++;
      else done = 1;
      @(posedge clk); #1;
      if (!done && wb_reg_write !== 1'b0) bubble_bad++;
      cyc++;
    end
    timeout = !done;
    idle_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs(); rst = 1;
    @(posedge clk); @(posedge clk); #1;
    total++; if (dmem_bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", dmem_bus.req); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_o); end
    total++; if ({wb_data, wb_rd, wb_reg_write} !== '0) begin bad++; $display("FAIL reset_wb got=%h/%0d/%0b want=0", wb_data, wb_rd, wb_reg_write); end
    total++; if ({misalign_o, misalign_addr} !== '0) begin bad++; $display("FAIL reset_misalign got=%0b/%h want=0", misalign_o, misalign_addr); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, IDLE); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_alu();
    int rq, st, bb; logic [31:0] ba, bw; logic bwe, to;
    drive_op(0, 0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 1, rq, st, bb, ba, bw, bwe, to);
    total++; if (rq !== 0 || st !== 0 || to) begin bad++; $display("FAIL alu_handshake req=%0d stall=%0d to=%0b want 0/0/0", rq, st, to); end
    total++; if (wb_data !== 32'h1234 || wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin bad++; $display("FAIL alu_wb got=%h/%0d/%0b want=00001234/5/1", wb_data, wb_rd, wb_reg_write); end
  endtask

  task automatic test_store();
    int rq, st, bb; logic [31:0] ba, bw; logic bwe, to;
    drive_op(0, 1, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 0, 1, rq, st, bb, ba, bw, bwe, to);
    total++; if (rq !== 1 || st !== 0 || to) begin bad++; $display("FAIL store_handshake req=%0d stall=%0d want 1/0", rq, st); end
    total++; if (ba !== 32'h100 || bw !== 32'hDEADBEEF || bwe !== 1'b1) begin bad++; $display("FAIL store_bus got=%h/%h/%0b want=00000100/deadbeef/1", ba, bw, bwe); end
    total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL store_wb got=%0b want=0", wb_reg_write); end
    // read and write together behave as a store; grant after two waits
    drive_op(1, 1, 32'h104, 32'h0BAD_F00D, 5'd0, 0, 0, 2, 1, rq, st, bb, ba, bw, bwe, to);
    total++; if (rq !== 3 || st !== 2 || bwe !== 1'b1 || bw !== 32'h0BAD_F00D || to) begin bad++; $display("FAIL store_rw_wait req=%0d stall=%0d we=%0b wdata=%h want 3/2/1/0badf00d", rq, st, bwe, bw); end
  endtask

  task automatic test_load_wait();
    int rq, st, bb; logic [31:0] ba, bw; logic bwe, to;
    mem_model[32'h200] = 32'hCAFEF00D;
    drive_op(1, 0, 32'h200, 32'h0, 5'd7, 1, 1, 2, 3, rq, st, bb, ba, bw, bwe, to);
    total++; if (st !== 5 || rq !== 3 || to) begin bad++; $display("FAIL load_wait_cycles stall=%0d req=%0d want 5/3", st, rq); end
    total++; if (bb !== 0) begin bad++; $display("FAIL load_wait_bubble got=%0d want=0", bb); end
    total++; if (wb_data !== 32'hCAFEF00D || wb_rd !== 5'd7 || wb_reg_write !== 1'b1) begin bad++; $display("FAIL load_wait_wb got=%h/%0d/%0b want=cafef00d/7/1", wb_data, wb_rd, wb_reg_write); end
  endtask

  task automatic test_misalign();
    int rq, st, bb; logic [31:0] ba, bw; logic bwe, to;
    drive_op(1, 0, 32'h203, 32'h0, 5'd9, 1, 1, 0, 1, rq, st, bb, ba, bw, bwe, to);
    total++; if (rq !== 0 || st !== 0) begin bad++; $display("FAIL misalign_handshake req=%0d stall=%0d want 0/0", rq, st); end
    total++; if (misalign_o !== 1'b1 || misalign_addr !== 32'h203 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL misalign_report got=%0b/%h/%0b want=1/00000203/0", misalign_o, misalign_addr, wb_reg_write); end
    @(posedge clk); #1;
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL misalign_pulse got=%0b want=0", misalign_o); end
  endtask

  task automatic test_rd0();
    int rq, st, bb; logic [31:0] ba, bw; logic bwe, to;
    drive_op(1, 0, 32'h208, 32'h0, 5'd0, 1, 1, 1, 1, rq, st, bb, ba, bw, bwe, to);
    total++; if (rq !== 2 || st !== 2 || ba !== 32'h208 || to) begin bad++; $display("FAIL rd0_access req=%0d stall=%0d addr=%h want 2/2/00000208", rq, st, ba); end
    total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL rd0_wb got=%0b want=0", wb_reg_write); end
  endtask

  task automatic test_reset_mid();
    int rq, st, bb; logic [31:0] ba, bw; logic bwe, to;
    @(negedge clk);
    alu_out_in = 32'h300; rd_in = 5'd4; reg_write_in = 1; mem_read_in = 1; mem_to_reg_in = 1;
    dmem_bus.gnt = 1;
    @(posedge clk); #1;
    total++; if (state_dbg !== WAIT_RSP) begin bad++; $display("FAIL midrst_enter got=%0d want=%0d", state_dbg, WAIT_RSP); end
    @(negedge clk); idle_inputs();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; dmem_bus.rvalid = 1; dmem_bus.rdata = 32'hFFFF_0001;
    #1;
    total++; if (dmem_bus.req !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL midrst_comb req=%0b stall=%0b want 0/0", dmem_bus.req, stall_o); end
    @(posedge clk); @(posedge clk); #1;
    total++; if (state_dbg !== IDLE || {wb_data, wb_rd, wb_reg_write, misalign_o} !== '0) begin bad++; $display("FAIL midrst_outputs state=%0d wb=%h/%0d/%0b mis=%0b want 0/0/0/0/0", state_dbg, wb_data, wb_rd, wb_reg_write, misalign_o); end
    idle_inputs();
    drive_op(0, 0, 32'h55AA, 32'h0, 5'd3, 1, 0, 0, 1, rq, st, bb, ba, bw, bwe, to);
    total++; if (wb_data !== 32'h55AA || wb_rd !== 5'd3 || wb_reg_write !== 1'b1 || st !== 0) begin bad++; $display("FAIL midrst_follow got=%h/%0d/%0b stall=%0d want=000055aa/3/1/0", wb_data, wb_rd, wb_reg_write, st); end
  endtask

  task automatic test_random();
    int rq, st, bb, kind, gw, rwt, exp_stall, exp_req;
    logic [31:0] ba, bw, addr, sd, exp_d; logic bwe, to, ld, str, rw, m2r, exp_rw, exp_mis;
    logic [4:0] rd;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3); gw = $urandom_range(0, 3); rwt = $urandom_range(1, 3);
      addr = 32'h400 + {26'($urandom_range(0, 15)), 2'b00};
      sd = $urandom; rd = 5'($urandom); rw = 1'($urandom);
      ld = 0; str = 0; m2r = 0; exp_mis = 0;
      case (kind)
        0: begin addr = $urandom; exp_stall = 0; exp_req = 0; exp_d = addr; end
        1: begin ld = 1; m2r = 1; exp_stall = gw + rwt; exp_req = gw + 1; exp_d = mem_rd(addr); end
        2: begin str = 1; ld = 1'($urandom); rw = 0; exp_stall = gw; exp_req = gw + 1; exp_d = addr; end
        default: begin
          addr = addr | 32'($urandom_range(1, 3)); ld = 1'($urandom); str = !ld;
          exp_mis = 1; exp_stall = 0; exp_req = 0; exp_d = '0;
        end
      endcase
      exp_rw = exp_mis ? 1'b0 : (rw && rd != 5'd0);
      if (!exp_mis) exp_q.push_back(exp_d);
      drive_op(ld, str, addr, sd, rd, rw, m2r, gw, rwt, rq, st, bb, ba, bw, bwe, to);
      total++; if (to || st !== exp_stall || rq !== exp_req || bb !== 0) begin bad++; $display("FAIL rand_timing op=%0d kind=%0d stall=%0d req=%0d bubble=%0d to=%0b want %0d/%0d/0/0", n, kind, st, rq, bb, to, exp_stall, exp_req); end
      total++; if (wb_reg_write !== exp_rw || misalign_o !== exp_mis) begin bad++; $display("FAIL rand_flags op=%0d kind=%0d wbw=%0b mis=%0b want %0b/%0b", n, kind, wb_reg_write, misalign_o, exp_rw, exp_mis); end
      if (exp_mis) begin
        total++; if (misalign_addr !== addr) begin bad++; $display("FAIL rand_misaddr op=%0d got=%h want=%h", n, misalign_addr, addr); end
      end else begin
        exp_d = exp_q.pop_front();
        total++; if (wb_data !== exp_d || wb_rd !== rd) begin bad++; $display("FAIL rand_wb op=%0d kind=%0d got=%h/%0d want=%h/%0d", n, kind, wb_data, wb_rd, exp_d, rd); end
      end
      if (kind == 2) begin
        total++; if (ba !== addr || bw !== sd || bwe !== 1'b1) begin bad++; $display("FAIL rand_store_bus op=%0d got=%h/%h/%0b want=%h/%h/1", n, ba, bw, bwe, addr, sd); end
      end else if (kind == 1) begin
        total++; if (ba !== addr || bwe !== 1'b0) begin bad++; $display("FAIL rand_load_bus op=%0d got=%h/%0b want=%h/0", n, ba, bwe, addr); end
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_alu();
    test_store();
    test_load_wait();
    test_misalign();
    test_rd0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes ALU result, store data, rd and memory control bits. Runs a req/gnt/rvalid handshake to the data memory and raises a pipeline stall while an access is outstanding.
- Selects load data or the ALU result and registers the writeback bundle for the WB stage, so it also serves as the MEM/WB register.

Parameters:
WIDTH, 32, data and address width in bits (word = WIDTH/8 bytes; only 32 is supported).

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
alu_out_in  input  WIDTH  ALU result; memory address for loads and stores
store_data_in  input  WIDTH  store data
rd_in  input  5  destination register
reg_write_in  input  1  instruction writes rd
mem_read_in  input  1  load
mem_write_in  input  1  store
mem_to_reg_in  input  1  writeback selects load data
dmem_req  output  1  memory request valid
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  WIDTH  word-aligned byte address
dmem_wdata  output  WIDTH  write data
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  read data valid; earliest one cycle after gnt
dmem_rdata  input  WIDTH  read data
stall_o  output  1  upstream stages must hold; combinational
wb_data  output  WIDTH  registered writeback value
wb_rd  output  5  registered destination
wb_reg_write  output  1  registered write enable
misalign_o  output  1  one-cycle registered pulse on misaligned access
misalign_addr  output  WIDTH  registered faulting address

Behaviour:
- Reset: state IDLE; all registered outputs 0; latched request cleared; dmem_req=0 from the first cycle after the reset edge.
- An access is pending when acc = mem_read_in|mem_write_in. It is misaligned when acc and alu_out_in[1:0]!=0.
- Misaligned access:
  - No dmem_req is issued; stall_o=0.
  - Next edge: misalign_o=1, misalign_addr=alu_out_in, wb_reg_write=0.
- States: IDLE, WAIT_GNT, WAIT_RSP.
- IDLE with aligned acc:
  - dmem_req=1 combinationally, driven from the inputs.
  - {addr, wdata, we, rd, reg_write, mem_to_reg, alu_out} are latched on this edge.
  - Store with gnt: completes this cycle, stall_o=0, stays IDLE.
  - Load with gnt: stall_o=1, go to WAIT_RSP.
  - No gnt: stall_o=1, go to WAIT_GNT.
- WAIT_GNT:
  - dmem_req=1 driven from the latched copy; current inputs are ignored.
  - On gnt: a store completes (stall_o=0, go to IDLE); a load goes to WAIT_RSP with stall_o=1.
- WAIT_RSP:
  - dmem_req=0.
  - On rvalid: capture rdata, stall_o=0, go to IDLE.
  - Otherwise stall_o=1.
- dmem_rvalid is ignored outside WAIT_RSP, including a response returning after reset.
- Writeback register, updated every edge:
  - Completing cycle (stall_o=0): wb_data = mem_to_reg ? load data : alu_out; wb_rd = rd; wb_reg_write = reg_write && rd!=0. Fields come from the latched copy when completing from a WAIT state, from the inputs when completing in IDLE.
  - Stalled cycle: wb_reg_write=0 (bubble); wb_data and wb_rd hold.
- Non-memory instruction: 1-cycle latency, no stall.
- Load latency: 1 + grant wait + response wait cycles.
- Upstream contract: EX/MEM holds its contents while stall_o=1. The stage does not depend on this after the issue cycle.
- mem_read_in and mem_write_in both 1: treated as a store.
- Reset mid-operation: abort the access; no writeback; state returns to IDLE.

Decomposition:
- Shared package pipe_pkg:
  - mem_state_t enum (IDLE, WAIT_GNT, WAIT_RSP).
  - WORD_ALIGN_MASK constant.
  - A struct for the latched request {addr, wdata, we, rd, reg_write, mem_to_reg}.
- Single module; no sub-module is required.

Test Plan:
- ALU op, alu_out_in=0x1234, rd=5, reg_write=1 -> next edge wb_data=0x1234, wb_rd=5, wb_reg_write=1; dmem_req never asserted; stall_o=0.
- Store to 0x100, data 0xDEADBEEF, gnt same cycle -> dmem_req=1, we=1, addr=0x100, wdata=0xDEADBEEF for one cycle; stall_o=0; wb_reg_write=0.
- Load from 0x200, rd=7, gnt after 2 cycles, rvalid 3 cycles later with rdata=0xCAFEF00D -> stall_o=1 for 5 cycles and dmem_req=1 for exactly 3 cycles; inputs changed to garbage during the stall are ignored; after rvalid wb_data=0xCAFEF00D, wb_rd=7, wb_reg_write=1.
- Load from 0x203 -> no dmem_req; misalign_o=1 for one cycle with misalign_addr=0x203; wb_reg_write=0.
- Load with rd=0, mem_to_reg=1 -> access performed; wb_reg_write=0.
- rst asserted in WAIT_RSP, then rvalid=1 -> dmem_req=0; state IDLE; all outputs 0; rvalid ignored; a following ALU op completes normally.
